ex_stage: RTL and testbench

Execute stage of the five-stage in-order pipeline, between ID and MEM. It computes the ALU result, or runs an iterative 32-bit divide. It detects misaligned memory addresses (ALE) and forwards the result to ID over the bypass. Its registered output bus and exception bus feed MEM through the valid/ready handshake used by every stage.

---
 rtl/ex_stage_pkg.sv | 65 ++++++
 rtl/ex_stage_div.sv | 102 ++++++++++
 rtl/ex_stage.sv | 143 ++++++++++++++
 tb/tb_ex_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the EX stage: bus widths, field positions, opcode bit
// indices, exception bit positions and the divider state encoding.
package ex_stage_pkg;

  localparam int unsigned CTRL_W = 192;
  localparam int unsigned MEM_W  = 220;
  localparam int unsigned CSR_W  = 47;
  localparam int unsigned EXCP_W = 16;
  localparam int unsigned BYP_W  = 39;

  // id_ctrl_bus field positions
  localparam int unsigned F_BREAK   = 191;
  localparam int unsigned F_DIV_HI  = 190;
  localparam int unsigned F_DIV_LO  = 187;
  localparam int unsigned F_OPM_HI  = 186;
  localparam int unsigned F_OPM_LO  = 181;
  localparam int unsigned F_ALU_HI  = 180;
  localparam int unsigned F_ALU_LO  = 167;
  localparam int unsigned F_IVALID  = 166;
  localparam int unsigned F_WIDX_HI = 69;
  localparam int unsigned F_WIDX_LO = 65;
  localparam int unsigned F_WEN     = 64;

  localparam int unsigned ALU_ADD   = 0;
  localparam int unsigned ALU_SUB   = 1;
  localparam int unsigned ALU_SLT   = 2;
  localparam int unsigned ALU_SLTU  = 3;
  localparam int unsigned ALU_AND   = 4;
  localparam int unsigned ALU_NOR   = 5;
  localparam int unsigned ALU_OR    = 6;
  localparam int unsigned ALU_XOR   = 7;
  localparam int unsigned ALU_SLL   = 8;
  localparam int unsigned ALU_SRL   = 9;
  localparam int unsigned ALU_SRA   = 10;
  localparam int unsigned ALU_LUI   = 11;
  localparam int unsigned ALU_MUL   = 12;
  localparam int unsigned ALU_MULH  = 13;

  localparam int unsigned DIV_W     = 0;
  localparam int unsigned DIV_WU    = 1;
  localparam int unsigned MOD_W     = 2;
  localparam int unsigned MOD_WU    = 3;

  // op_mem bits: enable, unsigned-load, store, byte, half, word access
  localparam int unsigned OPM_EN    = 0;
  localparam int unsigned OPM_UNS   = 1;
  localparam int unsigned OPM_ST    = 2;
  localparam int unsigned OPM_B     = 3;
  localparam int unsigned OPM_H     = 4;
  localparam int unsigned OPM_W     = 5;

  localparam int unsigned EXCP_ANY  = 0;
  localparam int unsigned EXCP_ALE  = 9;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  function automatic logic [31:0] mag32(input logic [31:0] x, input logic sgn);
    return (sgn && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// div_iter: 32-iteration restoring divider with sign fix-up and the
// divide-by-zero / overflow results of the ISA.
module div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  input  logic        flush_i,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  div_state_e  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dsr_q, dsr_d, dvd_q, dvd_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [32:0] shifted, diff;
  logic        fits;

  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dsr_q};
  assign fits    = shifted >= {1'b0, dsr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dsr_d   = dsr_q;
    dvd_d   = dvd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    unique case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          state_d = DIV_BUSY;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = mag32(dividend_i, signed_i);
          dsr_d   = mag32(divisor_i, signed_i);
          dvd_d   = dividend_i;
          qneg_d  = signed_i & (dividend_i[31] ^ divisor_i[31]);
          rneg_d  = signed_i & dividend_i[31];
          dz_d    = (divisor_i == '0);
        end
      end
      DIV_BUSY: begin
        rem_d = 32'(fits ? diff : shifted);
        quo_d = {quo_q[30:0], fits};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        if (ack_i) state_d = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase
    if (flush_i) begin
      state_d = DIV_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      dvd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dsr_q   <= dsr_d;
      dvd_q   <= dvd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign busy_o      = (state_q == DIV_BUSY);
  assign done_o      = (state_q == DIV_DONE);
  // 0x80000000 / -1 needs no special case: the negated magnitude wraps back.
  assign quotient_o  = dz_q ? '1 : (qneg_q ? (~quo_q + 32'd1) : quo_q);
  assign remainder_o = dz_q ? dvd_q : (rneg_q ? (~rem_q + 32'd1) : rem_q);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: inline ALU, misaligned-address check, bypass to ID and the
// registered hand-off to MEM. Macro DIV_EN builds the iterative divider.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              excp_flush,
  input  logic              ertn_flush,
  input  logic [CTRL_W-1:0] id_ctrl_bus,
  output logic [MEM_W-1:0]  mem_ctrl_bus,
  input  logic [CSR_W-1:0]  id_csr_bus,
  output logic [CSR_W-1:0]  ex_csr_bus,
  input  logic [EXCP_W-1:0] id_excp_bus,
  output logic [EXCP_W-1:0] ex_excp_bus,
  output logic [BYP_W-1:0]  ex_bypass,
  input  logic              left_valid,
  output logic              left_ready,
  output logic              right_valid,
  input  logic              right_ready,
  output logic              is_fire,
  input  logic              fire
);

  logic [3:0]  div_op;
  logic [5:0]  op_mem, op_mem_out;
  logic [13:0] alu_op;
  logic [31:0] src1, src2, alu_res, div_res, result;
  logic [4:0]  wreg_index;
  logic        wreg_en, is_div, flush, done, accept, ale;
  logic signed [63:0] prod;

  assign div_op     = id_ctrl_bus[F_DIV_HI:F_DIV_LO];
  assign op_mem     = id_ctrl_bus[F_OPM_HI:F_OPM_LO];
  assign alu_op     = id_ctrl_bus[F_ALU_HI:F_ALU_LO];
  assign wreg_index = id_ctrl_bus[F_WIDX_HI:F_WIDX_LO];
  assign wreg_en    = id_ctrl_bus[F_WEN];
  assign src2       = id_ctrl_bus[63:32];
  assign src1       = id_ctrl_bus[31:0];
  assign is_div     = |div_op;
  assign flush      = excp_flush | ertn_flush;

  assign prod = $signed({{32{src1[31]}}, src1}) * $signed({{32{src2[31]}}, src2});

  always_comb begin
    alu_res = '0;
    if      (alu_op[ALU_ADD])  alu_res = src1 + src2;
    else if (alu_op[ALU_SUB])  alu_res = src1 - src2;
    else if (alu_op[ALU_SLT])  alu_res = {31'b0, $signed(src1) < $signed(src2)};
    else if (alu_op[ALU_SLTU]) alu_res = {31'b0, src1 < src2};
    else if (alu_op[ALU_AND])  alu_res = src1 & src2;
    else if (alu_op[ALU_NOR])  alu_res = ~(src1 | src2);
    else if (alu_op[ALU_OR])   alu_res = src1 | src2;
    else if (alu_op[ALU_XOR])  alu_res = src1 ^ src2;
    else if (alu_op[ALU_SLL])  alu_res = src1 << src2[4:0];
    else if (alu_op[ALU_SRL])  alu_res = src1 >> src2[4:0];
    else if (alu_op[ALU_SRA])  alu_res = $signed(src1) >>> src2[4:0];
    else if (alu_op[ALU_LUI])  alu_res = src2;
    else if (alu_op[ALU_MUL])  alu_res = prod[31:0];
    else if (alu_op[ALU_MULH]) alu_res = prod[63:32];
  end

`ifdef DIV_EN
  logic        div_busy, div_done, div_start, div_signed;
  logic [31:0] div_quo, div_rem;

  assign div_signed = div_op[DIV_W] | div_op[MOD_W];
  assign div_start  = left_valid & is_div & id_ctrl_bus[F_IVALID] & !flush
                    & !div_busy & !div_done;

  div_iter u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (div_start),
    .signed_i   (div_signed),
    .dividend_i (src1),
    .divisor_i  (src2),
    .flush_i    (flush),
    .ack_i      (accept),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  assign done    = !is_div | div_done;
  assign div_res = (div_op[MOD_W] | div_op[MOD_WU]) ? div_rem : div_quo;
`else
  assign done    = 1'b1;
  assign div_res = '0;
`endif

  assign result = is_div ? div_res : alu_res;

  assign ale = op_mem[OPM_EN] & ((op_mem[OPM_W] & |alu_res[1:0]) |
                                 (op_mem[OPM_H] & alu_res[0]));
  assign op_mem_out = {op_mem[5:1], op_mem[OPM_EN] & !ale};

  assign left_ready = !(is_div & left_valid & !done);
  assign accept     = left_valid & done & right_ready & !flush;
  assign is_fire    = accept;

  logic [MEM_W-1:0]  mem_q, mem_d;
  logic [CSR_W-1:0]  csr_q;
  logic [EXCP_W-1:0] excp_q, excp_d;
  logic              valid_q, valid_d;

  assign mem_d = {id_ctrl_bus[F_BREAK], op_mem_out, id_ctrl_bus[F_ALU_HI:0], result};

  always_comb begin
    excp_d = id_excp_bus;
    if (ale) begin
      excp_d[EXCP_ALE] = 1'b1;
      excp_d[EXCP_ANY] = 1'b1;
    end
  end

  assign valid_d = (fire ? 1'b0 : valid_q) | accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q   <= '0;
      csr_q   <= '0;
      excp_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (accept) begin
        mem_q  <= mem_d;
        csr_q  <= id_csr_bus;
        excp_q <= excp_d;
      end
      valid_q <= flush ? 1'b0 : valid_d;
    end
  end

  assign mem_ctrl_bus = mem_q;
  assign ex_csr_bus   = csr_q;
  assign ex_excp_bus  = excp_q;
  assign right_valid  = valid_q;
  assign ex_bypass    = {result, wreg_index, wreg_en & left_valid,
                         op_mem[OPM_EN] & !op_mem[OPM_ST]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; divide expectations follow DIV_EN.
module tb_ex_stage;

`ifdef DIV_EN
  localparam bit HAS_DIV = 1'b1;
  localparam int DIV_LAT = 33;
`else
  localparam bit HAS_DIV = 1'b0;
  localparam int DIV_LAT = 0;
`endif

  logic         clk = 1'b0;
  logic         reset, excp_flush, ertn_flush;
  logic [191:0] id_ctrl_bus;
  logic [219:0] mem_ctrl_bus;
  logic [46:0]  id_csr_bus, ex_csr_bus;
  logic [15:0]  id_excp_bus, ex_excp_bus;
  logic [38:0]  ex_bypass;
  logic         left_valid, left_ready, right_valid, right_ready, is_fire, fire;

  int checks = 0;
  int failures = 0;

  ex_stage dut (
    .clk(clk), .reset(reset), .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .id_ctrl_bus(id_ctrl_bus), .mem_ctrl_bus(mem_ctrl_bus),
    .id_csr_bus(id_csr_bus), .ex_csr_bus(ex_csr_bus),
    .id_excp_bus(id_excp_bus), .ex_excp_bus(ex_excp_bus), .ex_bypass(ex_bypass),
    .left_valid(left_valid), .left_ready(left_ready),
    .right_valid(right_valid), .right_ready(right_ready),
    .is_fire(is_fire), .fire(fire)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [219:0] got, input logic [219:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  localparam logic [31:0] IMM  = 32'h00000abc;
  localparam logic [31:0] PC   = 32'h1c000100;
  localparam logic [31:0] INST = 32'h00100000;

  function automatic logic [191:0] mk(input logic [3:0] dop, input logic [5:0] opm,
                                      input logic [13:0] aop, input logic [31:0] s1,
                                      input logic [31:0] s2);
    return {1'b0, dop, opm, aop, 1'b1, IMM, PC, INST, 5'd7, 1'b1, s2, s1};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [3:0] dop, input logic [5:0] opm,
                        input logic [13:0] aop, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [31:0] res, input logic [5:0] opm_exp,
                        input logic [15:0] excp_in, input logic [15:0] excp_exp, input int lat);
    int n;
    int lrlow;
    logic [219:0] exp_bus;
    logic ld;
    ld          = opm[0] & ~opm[2];
    exp_bus     = {1'b0, opm_exp, aop, 1'b1, IMM, PC, INST, 5'd7, 1'b1, s2, s1, res};
    id_ctrl_bus = mk(dop, opm, aop, s1, s2);
    id_excp_bus = excp_in;
    id_csr_bus  = {15'h1234, s1};
    left_valid  = 1'b1;
    right_ready = 1'b1;
    fire        = 1'b0;
    #1;
    n = 0;
    lrlow = 0;
    while (!is_fire && n < 100) begin
      if (!left_ready) lrlow++;
      cyc();
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_lrlow"}, lrlow, lat);
    chk({tag, "_byp"}, ex_bypass, {res, 5'd7, 1'b1, ld});
    cyc();
    left_valid = 1'b0;
    fire       = 1'b1;
    #1;
    chk({tag, "_rv"}, right_valid, 1'b1);
    chk({tag, "_bus"}, mem_ctrl_bus, exp_bus);
    chk({tag, "_excp"}, ex_excp_bus, excp_exp);
    chk({tag, "_csr"}, ex_csr_bus, {15'h1234, s1});
    chk({tag, "_bypwen"}, ex_bypass[1], 1'b0);
    cyc();
    fire = 1'b0;
    #1;
    chk({tag, "_rv0"}, right_valid, 1'b0);
  endtask

  int          a_idx [14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13};
  logic [31:0] a_s1  [14] = '{32'h5, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
                              32'hF0F0F0F0, 32'h12340000, 32'hFFFF0000, 32'h1,
                              32'h80000000, 32'h80000000, 32'h0, 32'hFFFFFFFD, 32'h80000000};
  logic [31:0] a_s2  [14] = '{32'hFFFFFFFF, 32'h5, 32'h1, 32'h1, 32'hFF00FF00,
                              32'h0F0F0000, 32'h00005678, 32'hFF00FF00, 32'h23,
                              32'h4, 32'h24, 32'h12345000, 32'h7, 32'h80000000};
  logic [31:0] a_exp [14] = '{32'h4, 32'hFFFFFFFE, 32'h1, 32'h0, 32'hF000F000,
                              32'h00000F0F, 32'h12345678, 32'h00FFFF00, 32'h8,
                              32'h08000000, 32'hF8000000, 32'h12345000, 32'hFFFFFFEB,
                              32'h40000000};

  logic [3:0]  d_op  [8] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0001, 4'b0100,
                             4'b0010, 4'b1000};
  logic [31:0] d_s1  [8] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd9, 32'd9, 32'h80000000,
                             32'h80000000, 32'd100, 32'd100};
  logic [31:0] d_s2  [8] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                             32'd7, 32'd7};
  logic [31:0] d_exp [8] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9,
                             32'h80000000, 32'h0, 32'd14, 32'd2};

  initial begin
    reset = 1'b1; excp_flush = 1'b0; ertn_flush = 1'b0;
    id_ctrl_bus = '0; id_csr_bus = '0; id_excp_bus = '0;
    left_valid = 1'b0; right_ready = 1'b0; fire = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst_rv", right_valid, 1'b0);
    chk("rst_bus", mem_ctrl_bus, '0);
    chk("rst_csr", ex_csr_bus, '0);
    chk("rst_excp", ex_excp_bus, '0);
    chk("rst_lr", left_ready, 1'b1);
    chk("rst_fire", is_fire, 1'b0);
    cyc();

    for (int i = 0; i < 14; i++)
      run_op($sformatf("alu%0d", a_idx[i]), 4'b0, 6'b0, 14'(1) << a_idx[i],
             a_s1[i], a_s2[i], a_exp[i], 6'b0, 16'h0, 16'h0, 0);
    run_op("mulh_neg", 4'b0, 6'b0, 14'(1) << 13, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF,
           6'b0, 16'h0, 16'h0, 0);
    run_op("alu_none", 4'b0, 6'b0, 14'b0, 32'h1234, 32'h5678, 32'h0, 6'b0, 16'h0, 16'h0, 0);

    for (int i = 0; i < 8; i++)
      run_op($sformatf("div%0d", i), d_op[i], 6'b0, 14'b0, d_s1[i], d_s2[i],
             HAS_DIV ? d_exp[i] : 32'h0, 6'b0, 16'h0, 16'h0, DIV_LAT);

    run_op("ldw_ale", 4'b0, 6'b100001, 14'b1, 32'h1000, 32'h2, 32'h1002, 6'b100000,
           16'h0, 16'h0201, 0);
    run_op("ldh_ok", 4'b0, 6'b010001, 14'b1, 32'h1000, 32'h2, 32'h1002, 6'b010001,
           16'h0, 16'h0, 0);
    run_op("sth_ale", 4'b0, 6'b010101, 14'b1, 32'h1000, 32'h3, 32'h1003, 6'b010100,
           16'h0, 16'h0201, 0);
    run_op("stw_ok", 4'b0, 6'b100101, 14'b1, 32'h1000, 32'h4, 32'h1004, 6'b100101,
           16'h0040, 16'h0040, 0);
    run_op("ldb_pass", 4'b0, 6'b001001, 14'b1, 32'h1000, 32'h3, 32'h1003, 6'b001001,
           16'h0041, 16'h0041, 0);

    // Flush during a divide: valid dropped, next instruction accepted at once
    id_ctrl_bus = mk(4'b0, 6'b0, 14'b1, 32'd1, 32'd1);
    left_valid = 1'b1; right_ready = 1'b1; fire = 1'b0;
    #1;
    chk("fl_prime_fire", is_fire, 1'b1);
    cyc();
    id_ctrl_bus = mk(4'b0010, 6'b0, 14'b0, 32'd100, 32'd7);
    #1;
    chk("fl_prime_rv", right_valid, 1'b1);
    for (int i = 0; i < (HAS_DIV ? 10 : 0); i++) begin
      chk("fl_busy_nofire", is_fire, 1'b0);
      cyc();
    end
    excp_flush = 1'b1;
    #1;
    chk("fl_nofire", is_fire, 1'b0);
    chk("fl_lr", left_ready, !HAS_DIV);
    cyc();
    excp_flush = 1'b0;
    id_ctrl_bus = mk(4'b0, 6'b0, 14'b1, 32'd2, 32'd3);
    #1;
    chk("fl_rv0", right_valid, 1'b0);
    chk("fl_add_fire", is_fire, 1'b1);
    chk("fl_add_lr", left_ready, 1'b1);
    cyc();
    left_valid = 1'b0; fire = 1'b1;
    #1;
    chk("fl_add_rv", right_valid, 1'b1);
    chk("fl_add_res", mem_ctrl_bus[31:0], 32'd5);
    cyc();
    fire = 1'b0;

    // Back-pressure in DONE, then simultaneous fire and accept
    id_ctrl_bus = mk(4'b0, 6'b0, 14'b1, 32'd1, 32'd1);
    left_valid = 1'b1; right_ready = 1'b1;
    #1;
    chk("st_prime_fire", is_fire, 1'b1);
    cyc();
    id_ctrl_bus = mk(4'b0010, 6'b0, 14'b0, 32'd100, 32'd7);
    right_ready = 1'b0;
    for (int i = 0; i < DIV_LAT; i++) cyc();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("st_nofire", is_fire, 1'b0);
      chk("st_hold", ex_bypass[38:7], HAS_DIV ? 32'd14 : 32'd0);
      chk("st_lr", left_ready, 1'b1);
      cyc();
    end
    right_ready = 1'b1; fire = 1'b1;
    #1;
    chk("st_fire", is_fire, 1'b1);
    cyc();
    left_valid = 1'b0;
    #1;
    chk("st_rv_keep", right_valid, 1'b1);
    chk("st_res", mem_ctrl_bus[31:0], HAS_DIV ? 32'd14 : 32'd0);
    cyc();
    fire = 1'b0;
    #1;
    chk("st_rv0", right_valid, 1'b0);

    // ertn_flush alone clears a pending output
    id_ctrl_bus = mk(4'b0, 6'b0, 14'b1, 32'd4, 32'd4);
    left_valid = 1'b1;
    #1;
    chk("er_fire", is_fire, 1'b1);
    cyc();
    left_valid = 1'b0; ertn_flush = 1'b1;
    #1;
    chk("er_rv", right_valid, 1'b1);
    cyc();
    ertn_flush = 1'b0;
    #1;
    chk("er_rv0", right_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
